// File: rtl/sps_pkg.sv
// Shared constants for the parking gate scheduler: FSM state encoding,
// gate select values and the default slot-pool size.
package sps_pkg;

   localparam int DEF_NUM_SLOTS = 8;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] WAIT  = 2'b01;
   localparam logic [1:0] ALLOC = 2'b10;

   localparam logic GATE_A = 1'b0;
   localparam logic GATE_B = 1'b1;

endpackage

// File: rtl/free_slot_encoder.sv
// Lowest-index priority encoder over the free-slot mask (inverted bitmap).
// Ports: free_mask (1 = slot free) -> index (lowest free), any_free.
module free_slot_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] free_mask,
   output logic [W-1:0] index,
   output logic         any_free
);

   // scan high to low so the lowest free index is written last
   always_comb begin
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (free_mask[i]) index = W'(i);
      end
   end

   assign any_free = |free_mask;

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shares one token-auth FSM and the slot pool between entry gates A and B.
// Inputs: clock, reset (sync, active-high), req_a/req_b (level),
//   token_ok/token_fail (pulses), exit_valid/exit_slot (exit event).
// Outputs (all registered): grant_a/grant_b, auth_start, slot_valid,
//   slot_id, deny, err_release, full, occupied.
// Optional: define SPS_AUTH_TIMEOUT_EN to abort WAIT after AUTH_TIMEOUT cycles.
module parking_gate_scheduler
   import sps_pkg::*;
#(
   parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
   parameter int SLOT_W       = 3,
   parameter int CNT_W        = 4,
   parameter int AUTH_TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              token_ok,
   input  logic              token_fail,
   input  logic              exit_valid,
   input  logic [SLOT_W-1:0] exit_slot,
   output logic              grant_a,
   output logic              grant_b,
   output logic              auth_start,
   output logic              slot_valid,
   output logic [SLOT_W-1:0] slot_id,
   output logic              deny,
   output logic              err_release,
   output logic              full,
   output logic [CNT_W-1:0]  occupied
);

   logic [1:0]           state;
   logic                 ptr;
   logic                 gate;
   logic [NUM_SLOTS-1:0] bitmap;
   logic [NUM_SLOTS-1:0] bitmap_nxt;
   logic [NUM_SLOTS-1:0] free_mask;
   logic [NUM_SLOTS-1:0] alloc_mask;
   logic [NUM_SLOTS-1:0] exit_mask;
   logic [SLOT_W-1:0]    free_idx;
   logic                 any_free;
   logic                 exit_err;
   logic [CNT_W-1:0]     pop;
   logic                 gate_req;
   logic                 sel;
   logic                 timeout_hit;

   assign free_mask = ~bitmap;

   free_slot_encoder #(
      .N (NUM_SLOTS),
      .W (SLOT_W)
   ) u_enc (
      .free_mask (free_mask),
      .index     (free_idx),
      .any_free  (any_free)
   );

   // out-of-range exit_slot matches no bit, so it reports as already free
   always_comb begin
      exit_mask = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (exit_valid && exit_slot == SLOT_W'(i)) exit_mask[i] = 1'b1;
      end
   end

   assign exit_err = exit_valid & ~|(exit_mask & bitmap);

   always_comb begin
      alloc_mask = '0;
      if (state == ALLOC && any_free) alloc_mask[free_idx] = 1'b1;
   end

   // allocation picks from the start-of-cycle bitmap, so a slot freed
   // in the same cycle is never handed out again immediately
   assign bitmap_nxt = (bitmap & ~exit_mask) | alloc_mask;

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         pop = pop + CNT_W'(bitmap_nxt[i]);
      end
   end

   assign gate_req = (gate == GATE_A) ? req_a : req_b;
   assign sel = (req_a & req_b) ? ptr : (req_a ? GATE_A : GATE_B);

`ifdef SPS_AUTH_TIMEOUT_EN
   localparam int TW = $clog2(AUTH_TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;

   // held at 0 outside WAIT, so it reads 0 in the first WAIT cycle
   always_ff @(posedge clock) begin
      if (reset || state != WAIT) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout_hit = (state == WAIT) &&
                        (wait_cnt == TW'(AUTH_TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= GATE_A;
         gate        <= GATE_A;
         bitmap      <= '0;
         grant_a     <= 1'b0;
         grant_b     <= 1'b0;
         auth_start  <= 1'b0;
         slot_valid  <= 1'b0;
         slot_id     <= '0;
         deny        <= 1'b0;
         err_release <= 1'b0;
         full        <= 1'b0;
         occupied    <= '0;
      end else begin
         auth_start  <= 1'b0;
         slot_valid  <= 1'b0;
         slot_id     <= '0;
         deny        <= 1'b0;
         err_release <= exit_err;
         bitmap      <= bitmap_nxt;
         occupied    <= pop;
         full        <= (pop == CNT_W'(NUM_SLOTS));
         case (state)
            IDLE: begin
               if (!full && (req_a || req_b)) begin
                  gate       <= sel;
                  grant_a    <= (sel == GATE_A);
                  grant_b    <= (sel == GATE_B);
                  auth_start <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // car leaving outranks any result in the same cycle
               if (!gate_req) begin
                  grant_a <= 1'b0;
                  grant_b <= 1'b0;
                  ptr     <= ~ptr;
                  state   <= IDLE;
               end else if (token_ok) begin
                  ptr   <= ~ptr;
                  state <= ALLOC;
               end else if (token_fail || timeout_hit) begin
                  deny    <= 1'b1;
                  grant_a <= 1'b0;
                  grant_b <= 1'b0;
                  ptr     <= ~ptr;
                  state   <= IDLE;
               end
            end
            ALLOC: begin
               slot_valid <= any_free;
               slot_id    <= free_idx;
               grant_a    <= 1'b0;
               grant_b    <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench for parking_gate_scheduler: directed plan steps
// followed by random sessions and exits against a slot-set model.
module tb_parking_gate_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic       token_ok = 1'b0;
   logic       token_fail = 1'b0;
   logic       exit_valid = 1'b0;
   logic [2:0] exit_slot = '0;
   logic       grant_a;
   logic       grant_b;
   logic       auth_start;
   logic       slot_valid;
   logic [2:0] slot_id;
   logic       deny;
   logic       err_release;
   logic       full;
   logic [3:0] occupied;

   int n_cmp = 0;
   int n_err = 0;

   // model: which slots hold a car, and whose turn it is on contention
   bit occ [8];
   int ptr = 0;

   parking_gate_scheduler dut (
      .clock       (clock),
      .reset       (reset),
      .req_a       (req_a),
      .req_b       (req_b),
      .token_ok    (token_ok),
      .token_fail  (token_fail),
      .exit_valid  (exit_valid),
      .exit_slot   (exit_slot),
      .grant_a     (grant_a),
      .grant_b     (grant_b),
      .auth_start  (auth_start),
      .slot_valid  (slot_valid),
      .slot_id     (slot_id),
      .deny        (deny),
      .err_release (err_release),
      .full        (full),
      .occupied    (occupied)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cars();
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(occ[i]);
      return c;
   endfunction

   function automatic int low_free();
      for (int i = 0; i < 8; i++) if (!occ[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] all_outs();
      return {grant_a, grant_b, auth_start, slot_valid, slot_id,
              deny, err_release, full, occupied};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) occ[i] = 1'b0;
      ptr = 0;
   endtask

   task automatic do_reset();
      req_a = 0; req_b = 0; token_ok = 0; token_fail = 0;
      exit_valid = 0;
      reset = 1;
      tick();
      chk("reset_outs", all_outs(), 0);
      reset = 0;
      model_clear();
   endtask

   // outcome: 0 = token_ok, 1 = token_fail, 2 = car leaves (abort)
   task automatic session(input bit ra, input bit rb, input int outcome,
                          input int dly, input bit ex, input int exs);
      int g;
      int s;
      bit err_exp;
      logic [1:0] gexp;
      req_a = ra;
      req_b = rb;
      if (cars() == 8) begin
         tick();
         chk("held_off", {grant_a, grant_b}, 0);
         req_a = 0;
         req_b = 0;
         return;
      end
      g = (ra && rb) ? ptr : (ra ? 0 : 1);
      gexp = (g == 0) ? 2'b10 : 2'b01;
      tick();
      chk("grant", {grant_a, grant_b}, gexp);
      chk("auth_start", auth_start, 1);
      repeat (dly) begin
         tick();
         chk("auth_once", auth_start, 0);
         chk("grant_hold", {grant_a, grant_b}, gexp);
      end
      ptr = 1 - ptr;
      case (outcome)
         0: begin
            token_ok = 1;
            tick();
            token_ok = 0;
            chk("no_early_valid", slot_valid, 0);
            s = low_free();
            err_exp = 0;
            if (ex) begin
               exit_valid = 1;
               exit_slot = 3'(exs);
               err_exp = !occ[exs];
               if (!err_exp) occ[exs] = 0;
            end
            occ[s] = 1;
            tick();
            exit_valid = 0;
            chk("slot_valid", slot_valid, 1);
            chk("slot_id", slot_id, s);
            chk("occupied", occupied, cars());
            chk("full", full, cars() == 8);
            chk("grant_drop", {grant_a, grant_b}, 0);
            chk("alloc_err", err_release, ex && err_exp);
         end
         1: begin
            token_fail = 1;
            tick();
            token_fail = 0;
            chk("deny", deny, 1);
            chk("fail_grant", {grant_a, grant_b}, 0);
            chk("fail_occ", occupied, cars());
         end
         default: begin
            req_a = 0;
            req_b = 0;
            token_ok = 1;
            tick();
            token_ok = 0;
            chk("abort_deny", deny, 0);
            chk("abort_grant", {grant_a, grant_b}, 0);
            tick();
            chk("abort_noslot", slot_valid, 0);
            chk("abort_occ", occupied, cars());
         end
      endcase
   endtask

   task automatic do_exit(input int s, input bit tok);
      bit err_exp;
      req_a = 0;
      req_b = 0;
      exit_valid = 1;
      exit_slot = 3'(s);
      token_ok = tok;
      err_exp = !occ[s];
      if (!err_exp) occ[s] = 0;
      tick();
      exit_valid = 0;
      token_ok = 0;
      chk("err_release", err_release, err_exp);
      chk("exit_occ", occupied, cars());
      chk("exit_full", full, cars() == 8);
      chk("stray_ok", slot_valid, 0);
   endtask

   initial begin
      int v;
      int o;
      do_reset();

      session(1, 0, 0, 3, 0, 0);

      do_reset();
      repeat (3) session(1, 1, 0, 1, 0, 0);

      session(1, 0, 1, 1, 0, 0);
      session(0, 1, 2, 2, 0, 0);

      do_reset();
      repeat (8) session(1, 0, 0, 0, 0, 0);
      session(0, 1, 0, 0, 0, 0);
      do_exit(3, 0);
      session(0, 1, 0, 0, 0, 0);
      do_exit(5, 0);
      do_exit(5, 1);
      session(1, 0, 0, 1, 1, 0);

      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_exit($urandom_range(0, 7), 1'($urandom_range(0, 1)));
         end else begin
            v = $urandom_range(1, 3);
            o = $urandom_range(0, 9);
            o = (o < 6) ? 0 : ((o < 8) ? 1 : 2);
            session(v[0], v[1], o, $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7));
         end
      end

      req_a = 1;
      tick();
      chk("pre_reset_grant", grant_a, 1);
      reset = 1;
      token_ok = 1;
      tick();
      chk("reset_in_wait", all_outs(), 0);
      reset = 0;
      token_ok = 0;
      req_a = 0;
      model_clear();
      tick();
      chk("after_reset", all_outs(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
